poly_dds_core: RTL and testbench

POLY_DDS_CORE -- requirements
Module: poly_dds_core

---
 rtl/dds_pkg.sv | 18 +
 rtl/poly_dds_core_if.sv | 37 +++
 rtl/dds_wave_shaper.sv | 26 ++
 rtl/poly_dds_core.sv | 138 +++++++++++++
 tb/tb_poly_dds_core.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared types for the polyphonic DDS core.
// Waveform mode encodings and sweep FSM states.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_PULSE  = 2'd3
  } wave_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dds_state_t;

endpackage

// File: rtl/poly_dds_core_if.sv
// Config write port plus valid/ready sample stream of the DDS core.
// master: config writer / sample consumer; slave: the core.
interface poly_dds_core_if #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int WAVE_WIDTH = 12,
  parameter int OUT_WIDTH  = 16
) ();
  localparam int VW = $clog2(NUM_VOICES);

  logic                  wr_en;
  logic [VW-1:0]         wr_voice;
  logic [ACC_WIDTH-1:0]  wr_tune;
  logic [1:0]            wr_mode;
  logic [WAVE_WIDTH-1:0] wr_pw;
  logic                  wr_voice_en;
  logic                  phase_sync;
  logic [OUT_WIDTH-1:0]  sample_out;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  busy;
  logic                  overrun;

  modport master (
    output wr_en, wr_voice, wr_tune, wr_mode,
    output wr_pw, wr_voice_en, phase_sync,
    output sample_ready,
    input  sample_out, sample_valid, busy, overrun
  );

  modport slave (
    input  wr_en, wr_voice, wr_tune, wr_mode,
    input  wr_pw, wr_voice_en, phase_sync,
    input  sample_ready,
    output sample_out, sample_valid, busy, overrun
  );
endinterface

// File: rtl/dds_wave_shaper.sv
// Combinational waveform shaper: truncated phase, mode, pw -> wave.
// phase is the top WAVE_WIDTH bits of the accumulator.
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int WAVE_WIDTH = 12
) (
  input  logic [WAVE_WIDTH-1:0] phase,
  input  wave_mode_t            mode,
  input  logic [WAVE_WIDTH-1:0] pw,
  output logic [WAVE_WIDTH-1:0] wave
);
  localparam int W = WAVE_WIDTH;

  always_comb begin
    wave = '0;
    unique case (mode)
      MODE_SAW:    wave = phase;
      MODE_SQUARE: wave = phase[W-1] ? '0 : '1;
      MODE_TRI:    wave = {phase[W-1] ? ~phase[W-2:0]
                                      : phase[W-2:0], 1'b0};
      MODE_PULSE:  wave = (phase < pw) ? '1 : '0;
      default:     wave = '0;
    endcase
  end
endmodule

// File: rtl/poly_dds_core.sv
// Time-multiplexed polyphonic DDS: one voice per cycle per sample tick.
// Ports: clk, rst_n, bus (config writes, sample stream, busy, overrun).
module poly_dds_core
  import dds_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int WAVE_WIDTH = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int SAMPLE_DIV = 64
) (
  input logic            clk,
  input logic            rst_n,
  poly_dds_core_if.slave bus
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int W  = WAVE_WIDTH;
  localparam int SW = W + VW;
  localparam int CW = $clog2(SAMPLE_DIV);

  dds_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic tick, start, run, done, last;
  logic [VW-1:0] vidx;

  logic [ACC_WIDTH-1:0] phase [NUM_VOICES];
  logic [ACC_WIDTH-1:0] tune  [NUM_VOICES];
  wave_mode_t           mode  [NUM_VOICES];
  logic [W-1:0]         pw    [NUM_VOICES];
  logic [NUM_VOICES-1:0] en;

  logic [W-1:0]  wave;
  logic [SW-1:0] term, acc;
  logic [OUT_WIDTH-1:0] smp;
  logic valid, ovr;

  assign tick = (cnt == CW'(SAMPLE_DIV - 1));
  assign last = (vidx == VW'(NUM_VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (tick) state_nx = ST_RUN;
      ST_RUN:  if (last) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    run   = 1'b0;
    done  = 1'b0;
    unique case (state)
      ST_IDLE: start = tick;
      ST_RUN:  run   = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vidx <= '0;
    else if (start) vidx <= '0;
    else if (run)   vidx <= last ? '0 : vidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        tune[i] <= '0;
        mode[i] <= MODE_SAW;
        pw[i]   <= '0;
      end
    end else if (bus.wr_en && (int'(bus.wr_voice) < NUM_VOICES)) begin
      tune[bus.wr_voice] <= bus.wr_tune;
      mode[bus.wr_voice] <= wave_mode_t'(bus.wr_mode);
      pw[bus.wr_voice]   <= bus.wr_pw;
      en[bus.wr_voice]   <= bus.wr_voice_en;
    end
  end

  // Sync beats the write-back of the voice being processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.phase_sync) begin
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
    end else if (run && en[vidx]) begin
      phase[vidx] <= phase[vidx] + tune[vidx];
    end
  end

  dds_wave_shaper #(.WAVE_WIDTH(W)) u_shaper (
    .phase (phase[vidx][ACC_WIDTH-1 -: W]),
    .mode  (mode[vidx]),
    .pw    (pw[vidx]),
    .wave  (wave)
  );

  // Offset-binary to two's complement, sign-extended to SW bits.
  assign term = {{VW{~wave[W-1]}}, ~wave[W-1], wave[W-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 acc <= '0;
    else if (start)             acc <= '0;
    else if (run && en[vidx])   acc <= acc + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp   <= OUT_WIDTH'(1) << (OUT_WIDTH - 1);
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else if (done) begin
      smp   <= OUT_WIDTH'({~acc[SW-1], acc[SW-2:0]})
               << (OUT_WIDTH - SW);
      valid <= 1'b1;
      if (valid && !bus.sample_ready) ovr <= 1'b1;
    end else if (valid && bus.sample_ready) begin
      valid <= 1'b0;
    end
  end

  assign bus.sample_out   = smp;
  assign bus.sample_valid = valid;
  assign bus.overrun      = ovr;
  assign bus.busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_poly_dds_core.sv
// Randomized self-checking bench for poly_dds_core.
// Reference model computes each sweep's sample with plain arithmetic.
module tb_poly_dds_core;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  poly_dds_core_if #(
    .NUM_VOICES(4), .ACC_WIDTH(16),
    .WAVE_WIDTH(12), .OUT_WIDTH(16)
  ) bus ();

  poly_dds_core #(
    .NUM_VOICES(4), .ACC_WIDTH(16), .WAVE_WIDTH(12),
    .OUT_WIDTH(16), .SAMPLE_DIV(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  int unsigned m_phase [4];
  int unsigned m_tune  [4];
  int unsigned m_mode  [4];
  int unsigned m_pw    [4];
  bit          m_en    [4];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wave_of(int unsigned p, int unsigned md,
                                 int unsigned pwv);
    int unsigned t;
    t = p / 16;
    case (md)
      0: return int'(t);
      1: return (p < 32768) ? 4095 : 0;
      2: return (t < 2048) ? int'(2 * t) : int'(2 * (4095 - t));
      default: return (t < pwv) ? 4095 : 0;
    endcase
  endfunction

  function automatic int unsigned model_sweep();
    int sum;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_en[i]) begin
        sum += wave_of(m_phase[i], m_mode[i], m_pw[i]) - 2048;
        m_phase[i] = (m_phase[i] + m_tune[i]) % 65536;
      end
    end
    return int'(unsigned'((sum + 8192) * 4));
  endfunction

  task automatic wr(input int v, input int unsigned tn,
                    input int unsigned md, input int unsigned p,
                    input bit e);
    bus.wr_en       = 1'b1;
    bus.wr_voice    = 2'(v);
    bus.wr_tune     = 16'(tn);
    bus.wr_mode     = 2'(md);
    bus.wr_pw       = 12'(p);
    bus.wr_voice_en = e;
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_tune[v] = tn;
    m_mode[v] = md;
    m_pw[v]   = p;
    m_en[v]   = e;
  endtask

  task automatic sync_now();
    bus.phase_sync = 1'b1;
    @(negedge clk);
    bus.phase_sync = 1'b0;
    for (int i = 0; i < 4; i++) m_phase[i] = 0;
  endtask

  // act 1: pulse phase_sync, act 2: retune voice0 to 0x2000,
  // both in the cycle voice0 is processed.
  task automatic get_sample(input int act, output logic [15:0] s);
    int k;
    k = 0;
    s = '0;
    while (bus.busy !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy !== 1'b1) begin
      chk("busy_timeout", 32'(bus.busy), 32'd1);
      return;
    end
    if (act == 1) bus.phase_sync = 1'b1;
    if (act == 2) begin
      bus.wr_en       = 1'b1;
      bus.wr_voice    = 2'd0;
      bus.wr_tune     = 16'h2000;
      bus.wr_mode     = 2'(m_mode[0]);
      bus.wr_pw       = 12'(m_pw[0]);
      bus.wr_voice_en = m_en[0];
    end
    @(negedge clk);
    bus.phase_sync = 1'b0;
    bus.wr_en      = 1'b0;
    k = 1;
    while (bus.busy === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'd5);
    chk("valid_rise", 32'(bus.sample_valid), 32'd1);
    s = bus.sample_out;
  endtask

  logic [15:0] s;
  int unsigned exp;
  int bad;

  initial begin
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_voice = '0;
    bus.wr_tune = '0;
    bus.wr_mode = '0;
    bus.wr_pw = '0;
    bus.wr_voice_en = 1'b0;
    bus.phase_sync = 1'b0;
    bus.sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 0; m_tune[i] = 0;
      m_mode[i] = 0; m_pw[i] = 0; m_en[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(bus.sample_out), 32'h8000);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, 32'h1000, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp = model_sweep();
      get_sample(0, s);
      chk($sformatf("saw_model%0d", i), 32'(s), exp);
      chk($sformatf("saw_const%0d", i), 32'(s),
          32'h6000 + 32'(i) * 32'h400);
    end
    @(negedge clk);
    chk("valid_clear", 32'(bus.sample_valid), 32'd0);

    for (int n = 0; n < 10; n++) begin
      for (int v = 0; v < 4; v++)
        wr(v, $urandom_range(0, 65535), $urandom_range(0, 3),
           $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
      exp = model_sweep();
      get_sample(0, s);
      chk($sformatf("rand%0d", n), 32'(s), exp);
    end

    sync_now();
    for (int v = 0; v < 4; v++) wr(v, 0, 1, 0, 1'b1);
    exp = model_sweep();
    get_sample(0, s);
    chk("square_model", 32'(s), exp);
    chk("square_const", 32'(s), 32'hFFF0);
    for (int v = 0; v < 4; v++) wr(v, 0, 2, 0, 1'b1);
    exp = model_sweep();
    get_sample(0, s);
    chk("tri_model", 32'(s), exp);
    chk("tri_const", 32'(s), 32'h0000);

    wr(0, 32'h1000, 0, 0, 1'b1);
    for (int v = 1; v < 4; v++) wr(v, 0, 0, 0, 1'b0);
    bus.sample_ready = 1'b0;
    exp = model_sweep();
    get_sample(0, s);
    chk("ovr_first", 32'(s), exp);
    chk("ovr_not_yet", 32'(bus.overrun), 32'd0);
    exp = model_sweep();
    get_sample(0, s);
    chk("ovr_second", 32'(s), exp);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    bus.sample_ready = 1'b1;
    @(negedge clk);
    chk("ovr_consumed", 32'(bus.sample_valid), 32'd0);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    for (int i = 0; i < 2; i++) begin
      exp = model_sweep();
      get_sample(0, s);
      chk($sformatf("pre_sync%0d", i), 32'(s), exp);
    end
    exp = model_sweep();
    for (int i = 0; i < 4; i++) m_phase[i] = 0;
    get_sample(1, s);
    chk("sync_sweep", 32'(s), exp);
    exp = model_sweep();
    get_sample(0, s);
    chk("post_sync_model", 32'(s), exp);
    chk("post_sync_const", 32'(s), 32'h6000);

    exp = model_sweep();
    m_tune[0] = 32'h2000;
    get_sample(2, s);
    chk("retune_cur", 32'(s), exp);
    chk("retune_cur_c", 32'(s), 32'h6400);
    exp = model_sweep();
    get_sample(0, s);
    chk("retune_n1", 32'(s), exp);
    chk("retune_n1_c", 32'(s), 32'h6800);
    exp = model_sweep();
    get_sample(0, s);
    chk("retune_n2", 32'(s), exp);
    chk("retune_n2_c", 32'(s), 32'h7000);

    bad = 0;
    while (bus.busy !== 1'b1 && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("mid_rst_out", 32'(bus.sample_out), 32'h8000);
    chk("mid_rst_ovr", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.sample_valid !== 1'b0) bad++;
    end
    chk("mid_rst_nosample", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
